// File: rtl/uart_program_loader_pkg.sv
// Shared types and defaults for the UART boot-time program loader.
package uart_program_loader_pkg;

    // Collector FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    localparam int          BYTE_W                 = 8;
    localparam int          BYTES_PER_WORD         = 2;
    localparam logic [15:0] MAP_INIT_ADDR_DEFAULT  = 16'd30;
    localparam int          TIMEOUT_CYCLES_DEFAULT = 50000;

    // True while a load is in progress (header seen, image not finished or aborted)
    function automatic logic is_loading(input load_state_t s);
        return (s == ST_LEN_LO) || (s == ST_DATA_HI) || (s == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte-receive and memory-write request signals between the loader and its neighbours.
interface uart_program_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    // Loader side: consumes bytes, issues memory writes
    modport master (
        input  rx_data, rx_valid, mem_ready,
        output mem_req, mem_addr, mem_data
    );

    // Environment side: UART receiver and memory controller
    modport slave (
        output rx_data, rx_valid, mem_ready,
        input  mem_req, mem_addr, mem_data
    );
endinterface

// File: rtl/uart_program_loader_word_buffer.sv
// One-entry holding register for an assembled word and its target address.
// overflow flags that the entry is occupied and not leaving this cycle,
// so a push now would have nowhere to go.
module uart_program_loader_word_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  overflow
);

    assign overflow = valid && !pop;

    // Entry register: a push may refill the slot in the same cycle it is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push && !overflow) begin
            valid <= 1'b1;
            addr  <= push_addr;
            data  <= push_data;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: collects a length-prefixed big-endian word stream from the UART
// and writes it to memory from address 0, diverting the map-init word to a
// dedicated output. Releases the CPU once the last write has been accepted.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 16,
    parameter int                    DATA_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] MAP_INIT_ADDR  = ADDR_WIDTH'(MAP_INIT_ADDR_DEFAULT),
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    uart_program_loader_if.master    bus,
    output logic [DATA_WIDTH-1:0]    mem_map_init_value,
    output logic                     cpu_enable,
    output logic                     load_active,
    output logic                     error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    load_state_t state, state_next;

    logic [BYTE_W-1:0]                len_hi;
    logic [BYTE_W-1:0]                hi_byte;
    logic [15:0]                      words_left;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [CNT_W-1:0]                 idle_cnt;
    logic                             timeout;

    logic                             take_len_hi;
    logic                             take_len_lo;
    logic                             take_hi;
    logic                             push_word;

    logic [15:0]                      len_full;
    logic [BYTES_PER_WORD*BYTE_W-1:0] word_in;

    logic                             buf_valid;
    logic                             buf_pop;
    logic                             buf_flush;
    logic                             buf_overflow;
    logic [ADDR_WIDTH-1:0]            buf_addr;
    logic [DATA_WIDTH-1:0]            buf_data;

    logic                             writer_active;
    logic                             is_map;

    assign len_full = {len_hi, bus.rx_data};
    assign word_in  = {hi_byte, bus.rx_data};
    assign timeout  = (idle_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Collector state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Collector next-state and byte-capture strobes; timeout and overrun abort to ERROR
    always_comb begin
        state_next  = state;
        take_len_hi = 1'b0;
        take_len_lo = 1'b0;
        take_hi     = 1'b0;
        push_word   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    take_len_hi = 1'b1;
                    state_next  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (timeout) begin
                    state_next = ST_ERROR;
                end else if (bus.rx_valid) begin
                    take_len_lo = 1'b1;
                    state_next  = (len_full == 16'd0) ? ST_DONE : ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (timeout) begin
                    state_next = ST_ERROR;
                end else if (bus.rx_valid) begin
                    take_hi    = 1'b1;
                    state_next = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (timeout) begin
                    state_next = ST_ERROR;
                end else if (words_left == 16'd0) begin
                    // Last word collected; finish only once its write has drained
                    if (!buf_valid) state_next = ST_DONE;
                end else if (bus.rx_valid) begin
                    push_word = 1'b1;
                    if (buf_overflow)            state_next = ST_ERROR;
                    else if (words_left == 16'd1) state_next = ST_DATA_LO;
                    else                          state_next = ST_DATA_HI;
                end
            end
            ST_DONE:  state_next = ST_DONE;
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Header, high-byte and address/word-count bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= '0;
            hi_byte    <= '0;
            words_left <= '0;
            wr_addr    <= '0;
        end else begin
            if (take_len_hi) len_hi     <= bus.rx_data;
            if (take_len_lo) words_left <= len_full;
            if (take_hi)     hi_byte    <= bus.rx_data;
            if (push_word && !buf_overflow) begin
                wr_addr    <= wr_addr + ADDR_WIDTH'(1);
                words_left <= words_left - 16'd1;
            end
        end
    end

    // Inter-byte idle counter; holds at the limit so the abort is not missed
    always_ff @(posedge clk) begin
        if (rst)                                   idle_cnt <= '0;
        else if (bus.rx_valid)                     idle_cnt <= '0;
        else if (!is_loading(state))               idle_cnt <= '0;
        else if (!timeout)                         idle_cnt <= idle_cnt + CNT_W'(1);
    end

    uart_program_loader_word_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_word_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push_word),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .push_addr (wr_addr),
        .push_data (DATA_WIDTH'(word_in)),
        .valid     (buf_valid),
        .addr      (buf_addr),
        .data      (buf_data),
        .overflow  (buf_overflow)
    );

    // Writer: memory words wait for mem_ready, the map-init word drains in one cycle
    assign writer_active = buf_valid && is_loading(state);
    assign is_map        = (buf_addr == MAP_INIT_ADDR);
    assign buf_pop       = writer_active && (is_map || bus.mem_ready);
    assign buf_flush     = (state == ST_ERROR);

    assign bus.mem_req   = writer_active && !is_map;
    assign bus.mem_addr  = buf_addr;
    assign bus.mem_data  = buf_data;

    // Capture of the diverted map-init word
    always_ff @(posedge clk) begin
        if (rst)                     mem_map_init_value <= '0;
        else if (writer_active && is_map) mem_map_init_value <= buf_data;
    end

    assign cpu_enable  = (state == ST_DONE);
    assign error       = (state == ST_ERROR);
    assign load_active = is_loading(state);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for the UART program loader with a simple memory responder.
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] map_val;
    logic        cpu_enable;
    logic        load_active;
    logic        error;

    always #5 clk = ~clk;

    uart_program_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    uart_program_loader dut (
        .clk                (clk),
        .rst                (rst),
        .bus                (bus),
        .mem_map_init_value (map_val),
        .cpu_enable         (cpu_enable),
        .load_active        (load_active),
        .error              (error)
    );

    int          total       = 0;
    int          passed      = 0;
    bit          resp_en     = 1'b1;
    int          ready_delay = 1;
    int          req_run     = 0;
    int          req_cycles  = 0;
    int          req_at_map  = 0;
    logic [31:0] wlog[$];

    // Memory responder: accepts a request ready_delay cycles after it appears, logs {addr,data}
    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                req_cycles++;
                if (bus.mem_addr == 16'd30) req_at_map++;
                if (resp_en) begin
                    req_run++;
                    if (req_run >= ready_delay) begin
                        wlog.push_back({bus.mem_addr, bus.mem_data});
                        bus.mem_ready = 1'b1;
                        @(negedge clk);
                        bus.mem_ready = 1'b0;
                        req_run = 0;
                    end
                end
            end else begin
                req_run = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wlog.delete();
        req_cycles = 0;
        req_at_map = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (cpu_enable || error) break;
            @(negedge clk);
        end
    endtask

    initial begin
        int          bad;
        logic [15:0] w;
        logic [15:0] a;

        rst          = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cpu_enable",  {31'd0, cpu_enable},  32'd0);
        check("rst_load_active", {31'd0, load_active}, 32'd0);
        check("rst_error",       {31'd0, error},       32'd0);
        check("rst_mem_req",     {31'd0, bus.mem_req}, 32'd0);
        check("rst_map_val",     {16'd0, map_val},     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two-word image, memory accepts 3 cycles after request
        ready_delay = 3;
        send_byte(8'h00, 4);
        check("t1_load_active", {31'd0, load_active}, 32'd1);
        send_byte(8'h02, 4);
        send_word(16'h1234, 4);
        send_word(16'hABCD, 4);
        wait_done(200);
        check("t1_cpu_enable",  {31'd0, cpu_enable},  32'd1);
        check("t1_load_active_done", {31'd0, load_active}, 32'd0);
        check("t1_error",       {31'd0, error},       32'd0);
        check("t1_write_count", wlog.size(),          32'd2);
        check("t1_write0",      wlog[0],              32'h0000_1234);
        check("t1_write1",      wlog[1],              32'h0001_ABCD);
        send_byte(8'h77, 2);
        check("t1_extra_byte_ignored", {30'd0, cpu_enable, error}, 32'd2);

        // Empty image
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("t2_cpu_enable_1cyc", {31'd0, cpu_enable}, 32'd1);
        repeat (5) @(negedge clk);
        check("t2_no_mem_req", req_cycles, 32'd0);

        // 32 words with the map-init word at address 30
        do_reset();
        ready_delay = 1;
        send_byte(8'h00, 2);
        send_byte(8'h20, 2);
        for (int i = 0; i < 32; i++) begin
            w = (i == 30) ? 16'hBEEF : (16'h1000 + 16'(i));
            send_word(w, 2);
        end
        wait_done(200);
        check("t3_cpu_enable",  {31'd0, cpu_enable}, 32'd1);
        check("t3_map_val",     {16'd0, map_val},    32'h0000_BEEF);
        check("t3_req_at_30",   req_at_map,          32'd0);
        check("t3_write_count", wlog.size(),         32'd31);
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            a = (i < 30) ? 16'(i) : 16'd31;
            if (wlog[i] !== {a, 16'h1000 + a}) bad++;
        end
        check("t3_bad_entries", bad, 32'd0);

        // Stall after the first header byte
        do_reset();
        send_byte(8'h00, 0);
        repeat (49990) @(negedge clk);
        check("t4_error_before_limit", {31'd0, error},       32'd0);
        check("t4_active_before_limit", {31'd0, load_active}, 32'd1);
        repeat (15) @(negedge clk);
        check("t4_error",       {31'd0, error},       32'd1);
        check("t4_load_active", {31'd0, load_active}, 32'd0);
        check("t4_cpu_enable",  {31'd0, cpu_enable},  32'd0);

        // Memory never accepts: second word overruns the buffer
        do_reset();
        resp_en = 1'b0;
        send_byte(8'h00, 2);
        send_byte(8'h05, 2);
        send_word(16'h1111, 2);
        check("t5_req_pending", {31'd0, bus.mem_req}, 32'd1);
        check("t5_no_error_yet", {31'd0, error},      32'd0);
        send_byte(8'h22, 2);
        send_byte(8'h22, 0);
        check("t5_error",       {31'd0, error},       32'd1);
        check("t5_req_dropped", {31'd0, bus.mem_req}, 32'd0);
        check("t5_load_active", {31'd0, load_active}, 32'd0);
        send_word(16'h3333, 2);
        check("t5_error_sticky", {30'd0, cpu_enable, error}, 32'd1);
        resp_en = 1'b1;

        // Reset in the middle of a word, then a clean single-word image
        do_reset();
        ready_delay = 2;
        send_byte(8'h00, 1);
        send_byte(8'h03, 1);
        send_byte(8'h12, 1);
        do_reset();
        send_byte(8'h00, 4);
        send_byte(8'h01, 4);
        send_word(16'h55AA, 4);
        wait_done(200);
        check("t6_cpu_enable",  {31'd0, cpu_enable}, 32'd1);
        check("t6_error",       {31'd0, error},      32'd0);
        check("t6_write_count", wlog.size(),         32'd1);
        check("t6_write0",      wlog[0],             32'h0000_55AA);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
